// File: rtl/gif_sram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : gif_sram_frame_reader
// Brief    : Streams one decoded GIF frame (two palette indices per SRAM word)
//            from external SRAM through a word FIFO, one pixel per request.
// Options  : GIF_READER_UFLOW_CNT_EN enables the saturating underflow counter.
// Revision : 1.0 - initial release
// ============================================================================
module gif_sram_frame_reader #(
   parameter int FRAME_WORDS = 38400,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_start,
   input  logic [19:0] frame_base,
   input  logic        pix_req,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   output logic        frame_done,
   output logic        underflow,
   output logic [15:0] underflow_count,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [19:0] SRAM_ADDR,
   input  logic [15:0] SRAM_DQ,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_UB_N
);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam int c_wc_w  = $clog2(FRAME_WORDS + 1);
   localparam int c_pc_w  = $clog2(2 * FRAME_WORDS + 1);
   localparam logic [c_wc_w-1:0]  c_last_word = c_wc_w'(FRAME_WORDS - 1);
   localparam logic [c_pc_w-1:0]  c_last_pix  = c_pc_w'(2 * FRAME_WORDS - 1);
   localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_fetch = 2'd1;
   localparam logic [1:0] c_st_drain = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [19:0]        r_addr;
   logic [c_wc_w-1:0]  r_word_cnt;
   logic [c_pc_w-1:0]  r_pix_cnt;
   logic [15:0]        r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_inflight;
   logic               r_byte_hi;
   logic               r_pix_valid;
   logic [7:0]         r_pix_data;
   logic               r_frame_done;
   logic               r_underflow;
   logic               r_mem_req;
   logic [19:0]        r_sram_addr;
   logic               r_oe_n;
   logic               r_ce_n;

   logic               w_space;
   logic               w_issue;
   logic               w_pop;
   logic               w_uflow;
   logic               w_push;
   logic               w_pop_word;
   logic [15:0]        w_head;
   logic [7:0]         w_byte;

   // Budget counts the read still in flight so a full FIFO can never overflow.
   assign w_space    = (r_count + c_cnt_w'(r_inflight)) < c_depth;
   assign w_push     = r_inflight && !frame_start;
   assign w_pop_word = w_pop && r_byte_hi;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_byte     = r_byte_hi ? w_head[15:8] : w_head[7:0];

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= c_st_idle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (frame_start) begin
         w_state_nxt = c_st_fetch;
      end else begin
         case (r_state)
            c_st_fetch: if (w_issue && (r_word_cnt == c_last_word)) w_state_nxt = c_st_drain;
            c_st_drain: if (w_pop && (r_pix_cnt == c_last_pix))     w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
         endcase
      end
   end

   // frame_start swallows any same-cycle issue or pixel request.
   always_comb begin
      w_issue = 1'b0;
      w_pop   = 1'b0;
      w_uflow = 1'b0;
      if (!frame_start) begin
         w_issue = (r_state == c_st_fetch) && mem_gnt && w_space;
         if ((r_state != c_st_idle) && pix_req) begin
            w_pop   = (r_count != '0);
            w_uflow = (r_count == '0);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_addr       <= '0;
         r_word_cnt   <= '0;
         r_pix_cnt    <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_inflight   <= 1'b0;
         r_byte_hi    <= 1'b0;
         r_pix_valid  <= 1'b0;
         r_pix_data   <= 8'h00;
         r_frame_done <= 1'b0;
         r_underflow  <= 1'b0;
         r_mem_req    <= 1'b0;
         r_sram_addr  <= '0;
         r_oe_n       <= 1'b1;
         r_ce_n       <= 1'b1;
      end else begin
         r_mem_req    <= (w_state_nxt == c_st_fetch);
         r_pix_valid  <= w_pop;
         r_pix_data   <= w_pop ? w_byte : 8'h00;
         r_frame_done <= w_pop && (r_pix_cnt == c_last_pix);
         r_oe_n       <= !w_issue;
         r_ce_n       <= !w_issue;
         if (w_issue) r_sram_addr <= r_addr;
         if (frame_start) begin
            r_addr      <= frame_base;
            r_word_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_inflight  <= 1'b0;
            r_byte_hi   <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
               r_addr     <= r_addr + 20'd1;
               r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_word) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop_word);
            if (w_pop) begin
               r_byte_hi <= !r_byte_hi;
               r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_uflow) r_underflow <= 1'b1;
         end
      end
   end

   // Storage carries no reset; occupancy alone says which entries are live.
   always_ff @(posedge Clk) begin
      if (w_push) r_mem[r_wr_ptr] <= SRAM_DQ;
   end

`ifdef GIF_READER_UFLOW_CNT_EN
   logic [15:0] r_uflow_cnt;

   always_ff @(posedge Clk) begin
      if (Reset)                                 r_uflow_cnt <= 16'h0000;
      else if (w_uflow && (r_uflow_cnt != 16'hFFFF)) r_uflow_cnt <= r_uflow_cnt + 16'd1;
   end

   assign underflow_count = r_uflow_cnt;
`else
   assign underflow_count = 16'h0000;
`endif

   assign pix_valid  = r_pix_valid;
   assign pix_data   = r_pix_data;
   assign frame_done = r_frame_done;
   assign underflow  = r_underflow;
   assign mem_req    = r_mem_req;
   assign SRAM_ADDR  = r_sram_addr;
   assign SRAM_OE_N  = r_oe_n;
   assign SRAM_CE_N  = r_ce_n;
   assign SRAM_WE_N  = 1'b1;
   assign SRAM_LB_N  = 1'b0;
   assign SRAM_UB_N  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_gif_sram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gif_sram_frame_reader
// Brief    : Self-checking bench for gif_sram_frame_reader against an
//            address-indexed SRAM image and a pixel-sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gif_sram_frame_reader;
   localparam int FW   = 48;
   localparam int FD   = 8;
   localparam int NPIX = 2 * FW;
`ifdef GIF_READER_UFLOW_CNT_EN
   localparam bit UCNT_EN = 1'b1;
`else
   localparam bit UCNT_EN = 1'b0;
`endif

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic        frame_start = 1'b0;
   logic [19:0] frame_base  = 20'h0;
   logic        pix_req     = 1'b0;
   logic        mem_gnt     = 1'b0;
   logic [15:0] key         = 16'h0;
   logic        pix_valid, frame_done, underflow, mem_req;
   logic [7:0]  pix_data;
   logic [15:0] underflow_count, SRAM_DQ;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_OE_N, SRAM_CE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

   int checks   = 0;
   int failures = 0;
   int uf_total = 0;

   always #5 clk = ~clk;

   gif_sram_frame_reader #(.FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
      .Clk(clk), .Reset(rst), .frame_start(frame_start), .frame_base(frame_base),
      .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
      .frame_done(frame_done), .underflow(underflow), .underflow_count(underflow_count),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
      .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
   );

   function automatic logic [15:0] sram_word(input logic [19:0] a, input logic [15:0] k);
      return a[15:0] ^ {4{a[19:16]}} ^ k;
   endfunction

   // Asynchronous SRAM image; junk on the bus whenever the part is not read-enabled.
   assign SRAM_DQ = (!SRAM_OE_N && !SRAM_CE_N) ? sram_word(SRAM_ADDR, key) : 16'hBEEF;

   function automatic logic [7:0] exp_pix(input logic [19:0] base, input int k);
      logic [15:0] w;
      w = sram_word(base + 20'(k / 2), key);
      return (k % 2 == 1) ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [15:0] exp_ucnt(input int n);
      if (!UCNT_EN) return 16'h0000;
      return (n > 65535) ? 16'hFFFF : 16'(n);
   endfunction

   task automatic start_frame(input logic [19:0] base, input logic req);
      frame_base  = base;
      frame_start = 1'b1;
      pix_req     = req;
      @(posedge clk); #1;
      frame_start = 1'b0;
      frame_base  = 20'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (6) begin
         frame_start = 1'($urandom);
         frame_base  = 20'($urandom);
         pix_req     = 1'($urandom);
         mem_gnt     = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({pix_valid, pix_data, frame_done, underflow, underflow_count, mem_req, SRAM_ADDR,
              SRAM_OE_N, SRAM_CE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} !==
             {1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got v=%b d=%h fd=%b uf=%b ucnt=%h req=%b a=%h oe=%b ce=%b we=%b lb=%b ub=%b exp v=0 d=00 a=00000 oe/ce/we=1 lb/ub=0",
                     pix_valid, pix_data, frame_done, underflow, underflow_count, mem_req, SRAM_ADDR,
                     SRAM_OE_N, SRAM_CE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N);
         end
      end
      frame_start = 1'b0;
      pix_req     = 1'b0;
      rst         = 1'b0;
      repeat (10) begin
         mem_gnt = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if (mem_req !== 1'b0 || SRAM_OE_N !== 1'b1 || pix_valid !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet got req=%b oe=%b v=%b uf=%b exp req=0 oe=1 v=0 uf=0",
                     mem_req, SRAM_OE_N, pix_valid, underflow);
         end
      end
   endtask

   task automatic test_frame_stream(input logic [19:0] base, input bit rnd);
      int got    = 0;
      int issued = 0;
      bit prev_req;
      key     = rnd ? 16'($urandom) : 16'h0000;
      mem_gnt = 1'b1;
      pix_req = 1'b0;
      start_frame(base, 1'b0);
      checks++;
      if (mem_req !== 1'b1 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL stream_start got req=%b uf=%b exp req=1 uf=0", mem_req, underflow);
      end
      pix_req  = 1'b1;
      prev_req = 1'b1;
      for (int cyc = 0; cyc < 40 * NPIX && got < NPIX; cyc++) begin
         @(posedge clk); #1;
         if (SRAM_OE_N === 1'b0) begin
            checks++;
            if (SRAM_ADDR !== base + 20'(issued) || issued >= FW) begin
               failures++;
               $display("FAIL stream_addr n=%0d got=%h exp=%h", issued, SRAM_ADDR, base + 20'(issued));
            end
            issued++;
         end
         if (pix_valid === 1'b1) begin
            checks++;
            if (!prev_req || pix_data !== exp_pix(base, got) || frame_done !== 1'(got == NPIX - 1)) begin
               failures++;
               $display("FAIL stream_pix idx=%0d got d=%h fd=%b exp d=%h fd=%b req=%b",
                        got, pix_data, frame_done, exp_pix(base, got), got == NPIX - 1, prev_req);
            end
            got++;
         end else begin
            if (prev_req) uf_total++;
            checks++;
            if (frame_done !== 1'b0 || pix_data !== 8'h00 || (prev_req && underflow !== 1'b1)) begin
               failures++;
               $display("FAIL stream_nopix got fd=%b d=%h uf=%b exp fd=0 d=00 uf=%b",
                        frame_done, pix_data, underflow, prev_req);
            end
         end
         checks++;
         if (underflow_count !== exp_ucnt(uf_total)) begin
            failures++;
            $display("FAIL stream_ucnt got=%0d exp=%0d", underflow_count, exp_ucnt(uf_total));
         end
         if (rnd) mem_gnt = ($urandom_range(0, 3) != 0);
         pix_req  = (got < NPIX) && (!rnd || $urandom_range(0, 2) != 0);
         prev_req = pix_req;
      end
      checks++;
      if (got != NPIX || issued != FW) begin
         failures++;
         $display("FAIL stream_totals got pix=%0d words=%0d exp pix=%0d words=%0d", got, issued, NPIX, FW);
      end
      pix_req = 1'b0;
      mem_gnt = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (mem_req !== 1'b0 || SRAM_OE_N !== 1'b1 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle got req=%b oe=%b v=%b exp req=0 oe=1 v=0", mem_req, SRAM_OE_N, pix_valid);
         end
      end
   endtask

   task automatic test_fifo_fill();
      logic [19:0] base;
      int issued = 0;
      key     = 16'($urandom);
      base    = 20'($urandom);
      mem_gnt = 1'b1;
      pix_req = 1'b0;
      start_frame(base, 1'b0);
      repeat (20) begin
         @(posedge clk); #1;
         if (SRAM_OE_N === 1'b0) begin
            checks++;
            if (SRAM_ADDR !== base + 20'(issued)) begin
               failures++;
               $display("FAIL fill_addr n=%0d got=%h exp=%h", issued, SRAM_ADDR, base + 20'(issued));
            end
            issued++;
         end
      end
      checks++;
      if (issued != FD) begin
         failures++;
         $display("FAIL fill_count got=%0d exp=%0d", issued, FD);
      end
      checks++;
      if (mem_req !== 1'b1 || SRAM_ADDR !== base + 20'(FD - 1)) begin
         failures++;
         $display("FAIL fill_hold got req=%b a=%h exp req=1 a=%h", mem_req, SRAM_ADDR, base + 20'(FD - 1));
      end
   endtask

   task automatic test_abort();
      logic [19:0] base1;
      int issued = 0;
      int got    = 0;
      key     = 16'($urandom);
      base1   = 20'($urandom);
      mem_gnt = 1'b1;
      pix_req = 1'b0;
      start_frame(base1, 1'b0);
      for (int cyc = 0; cyc < 20 && issued < 3; cyc++) begin
         @(posedge clk); #1;
         if (SRAM_OE_N === 1'b0) issued++;
         if (issued == 3) mem_gnt = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      pix_req = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== exp_pix(base1, 0)) begin
         failures++;
         $display("FAIL abort_prefetch got v=%b d=%h exp v=1 d=%h", pix_valid, pix_data, exp_pix(base1, 0));
      end
      mem_gnt = 1'b1;
      start_frame(20'h20000, 1'b1);
      checks++;
      if (pix_valid !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL abort_drop got v=%b uf=%b exp v=0 uf=0", pix_valid, underflow);
      end
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(posedge clk); #1;
         if (pix_valid === 1'b1) begin
            checks++;
            if (pix_data !== exp_pix(20'h20000, got)) begin
               failures++;
               $display("FAIL abort_pix idx=%0d got=%h exp=%h", got, pix_data, exp_pix(20'h20000, got));
            end
            got++;
         end else begin
            uf_total++;
         end
         if (got == 4) pix_req = 1'b0;
      end
      checks++;
      if (got != 4 || underflow_count !== exp_ucnt(uf_total)) begin
         failures++;
         $display("FAIL abort_totals got pix=%0d ucnt=%0d exp pix=4 ucnt=%0d", got, underflow_count, exp_ucnt(uf_total));
      end
      pix_req = 1'b0;
   endtask

   task automatic test_underflow();
      logic [19:0] base;
      bit seen = 1'b0;
      key     = 16'($urandom);
      base    = 20'($urandom);
      mem_gnt = 1'b0;
      pix_req = 1'b0;
      start_frame(base, 1'b1);
      checks++;
      if (underflow !== 1'b0 || pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL uflow_clear got uf=%b v=%b exp uf=0 v=0", underflow, pix_valid);
      end
      repeat (5) begin
         @(posedge clk); #1;
         uf_total++;
         checks++;
         if (pix_valid !== 1'b0 || pix_data !== 8'h00 || underflow !== 1'b1 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL uflow_flag got v=%b d=%h uf=%b req=%b exp v=0 d=00 uf=1 req=1",
                     pix_valid, pix_data, underflow, mem_req);
         end
      end
      checks++;
      if (underflow_count !== exp_ucnt(uf_total)) begin
         failures++;
         $display("FAIL uflow_count got=%0d exp=%0d", underflow_count, exp_ucnt(uf_total));
      end
      mem_gnt = 1'b1;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         @(posedge clk); #1;
         if (pix_valid === 1'b1) begin
            seen    = 1'b1;
            pix_req = 1'b0;
         end else begin
            uf_total++;
         end
      end
      checks++;
      if (!seen || pix_data !== exp_pix(base, 0) || underflow_count !== exp_ucnt(uf_total)) begin
         failures++;
         $display("FAIL uflow_resume got v=%b d=%h ucnt=%0d exp v=1 d=%h ucnt=%0d",
                  seen, pix_data, underflow_count, exp_pix(base, 0), exp_ucnt(uf_total));
      end
      pix_req = 1'b0;
   endtask

   task automatic test_wrap();
      logic [19:0] base;
      int issued = 0;
      int got    = 0;
      base    = 20'hFFFFE;
      key     = 16'($urandom);
      mem_gnt = 1'b1;
      pix_req = 1'b0;
      start_frame(base, 1'b0);
      repeat (14) begin
         @(posedge clk); #1;
         if (SRAM_OE_N === 1'b0) begin
            checks++;
            if (SRAM_ADDR !== base + 20'(issued)) begin
               failures++;
               $display("FAIL wrap_addr n=%0d got=%h exp=%h", issued, SRAM_ADDR, base + 20'(issued));
            end
            issued++;
         end
      end
      pix_req = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         @(posedge clk); #1;
         if (pix_valid === 1'b1) begin
            checks++;
            if (pix_data !== exp_pix(base, got)) begin
               failures++;
               $display("FAIL wrap_pix idx=%0d got=%h exp=%h", got, pix_data, exp_pix(base, got));
            end
            got++;
         end else begin
            uf_total++;
         end
         if (got == 8) pix_req = 1'b0;
      end
      checks++;
      if (got != 8 || issued != FD) begin
         failures++;
         $display("FAIL wrap_totals got pix=%0d words=%0d exp pix=8 words=%0d", got, issued, FD);
      end
      pix_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_stream(20'h00100, 1'b0);
      test_fifo_fill();
      test_abort();
      test_underflow();
      test_wrap();
      for (int r = 0; r < 3; r++) test_frame_stream(20'($urandom), 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
